// File: rtl/axis_spi_master.sv
// AXI-Stream to SPI master bridge.
// Each TX word from s_axis is shifted out MSB-first on MOSI while MISO is
// shifted in, and the received word is returned on m_axis. tuser picks the
// chip select for a frame, and tlast=0 keeps that chip select low for the
// next word. SCK, CS_N and MOSI all come straight from flops.
// With CPHA=0, MISO is captured one clk after the leading SCK edge, while SCK
// is still at !CPOL. The slave holds the bit until the trailing edge. On a
// back-to-back word, MOSI changes on the same clk as SHIFT entry, so looped-back
// data is still captured correctly.
module axis_spi_master #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CS     = 4,
    parameter int CLK_DIV    = 4,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input  logic                                          clk,
    input  logic                                          resetn,
    input  logic [31:0]                                   s_axis_tdata,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] s_axis_tuser,
    input  logic                                          s_axis_tlast,
    input  logic                                          s_axis_tvalid,
    output logic                                          s_axis_tready,
    output logic [31:0]                                   m_axis_tdata,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
    output logic                                          MOSI,
    input  logic                                          MISO,
    output logic                                          SCK,
    output logic [NUM_CS-1:0]                             CS_N,
    output logic                                          busy
);

    localparam int   SEL_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int   HALF     = CLK_DIV / 2;
    localparam int   CNT_W    = 16;
    localparam logic SCK_IDLE = 1'(CPOL);
    localparam logic [5:0] LAST_BIT = 6'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, CONT, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [5:0]             bit_q, bit_d;
    logic                   ready_en_q;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic                   last_q;
    logic                   sck_q, sck_d;
    logic [NUM_CS-1:0]      cs_n_q, cs_n_d;
    logic                   mosi_q;
    logic                   m_valid_q;
    logic [31:0]            m_data_q;
    logic                   s_hs, m_hs;
    logic                   cs_on_d, mosi_en_d, lead_d, trail, sample, shift, emit;
    logic [DATA_WIDTH-1:0]  din, tx_sr, rx_sr;
    logic                   unused_tdata;

    assign din           = s_axis_tdata[DATA_WIDTH-1:0];
    assign unused_tdata  = ^s_axis_tdata;
    assign s_axis_tready = ready_en_q && !m_valid_q && (state_q == IDLE || state_q == CONT);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign m_hs          = m_valid_q && m_axis_tready;
    assign busy          = (state_q != IDLE);
    assign SCK           = sck_q;
    assign CS_N          = cs_n_q;
    assign MOSI          = mosi_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;

    // State register: FSM state, shared phase/delay counter and bit index
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    // Next-state logic; cnt counts SETUP cycles, clk cycles within an SCK period, or HOLD cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        unique case (state_q)
            IDLE: if (s_hs) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = (CS_SETUP == 0) ? SHIFT : SETUP;
            end
            SETUP: if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                state_d = SHIFT;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            SHIFT: if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                cnt_d = '0;
                if (bit_q == LAST_BIT) state_d = last_q ? HOLD : CONT;
                else                   bit_d   = bit_q + 6'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            CONT: if (s_hs) begin
                state_d = SHIFT;
                cnt_d   = '0;
                bit_d   = '0;
            end
            HOLD: if (cnt_q == CNT_W'(CS_HOLD)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: next values of the registered pins plus shift/sample strobes
    always_comb begin
        sel_d     = (state_q == IDLE && s_hs) ? s_axis_tuser : sel_q;
        cs_on_d   = (state_d == SETUP) || (state_d == SHIFT) || (state_d == CONT) ||
                    (state_d == HOLD && cnt_d < CNT_W'(CS_HOLD));
        cs_n_d    = '1;
        for (int i = 0; i < NUM_CS; i++) cs_n_d[i] = !(cs_on_d && (sel_d == SEL_W'(i)));
        sck_d     = (state_d == SHIFT && cnt_d < CNT_W'(HALF)) ? !SCK_IDLE : SCK_IDLE;
        mosi_en_d = (state_d == SETUP) || (state_d == SHIFT) || (state_d == CONT);
        lead_d    = (state_d == SHIFT) && (cnt_d == '0);
        trail     = (state_q == SHIFT) && (cnt_q == CNT_W'(HALF - 1));
        sample    = (CPHA == 0) ? ((state_q == SHIFT) && (cnt_q == '0)) : trail;
        shift     = (CPHA == 0) ? (trail && bit_q != LAST_BIT) : lead_d;
        emit      = (state_q == SHIFT) && (bit_q == LAST_BIT) && (cnt_q == CNT_W'(HALF));
    end

    // Registered pins, frame attributes and the RX output word
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_en_q <= 1'b0;
            sck_q      <= SCK_IDLE;
            cs_n_q     <= '1;
            mosi_q     <= 1'b0;
            sel_q      <= '0;
            last_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
        end else begin
            ready_en_q <= 1'b1;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            sel_q      <= sel_d;
            if (s_hs) last_q <= s_axis_tlast;
            if (!mosi_en_d)
                mosi_q <= 1'b0;
            else if (s_hs)
                mosi_q <= (CPHA == 0 || lead_d) ? din[DATA_WIDTH-1] : 1'b0;
            else if (shift)
                mosi_q <= tx_sr[DATA_WIDTH-1];
            if (emit) begin
                m_valid_q <= 1'b1;
                m_data_q  <= 32'(rx_sr);
            end else if (m_hs) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    // Shift registers; tx_sr holds the bits not yet driven on MOSI
    always_ff @(posedge clk) begin
        if (s_hs)
            tx_sr <= (CPHA == 0 || lead_d) ? (din << 1) : din;
        else if (shift)
            tx_sr <= tx_sr << 1;
        if (sample)
            rx_sr <= {rx_sr[DATA_WIDTH-2:0], MISO};
    end

endmodule

// File: tb/tb_axis_spi_master.sv
// Directed bench for axis_spi_master.
// dut0: 8-bit mode 0 with 4 chip selects, MISO looped back from MOSI.
// dut1: 8-bit mode 3 with 3 chip selects, so tuser=3 is an unused select;
// MISO is either tied high or looped back.
module tb_axis_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [31:0] s_tdata0, s_tdata1, m_tdata0, m_tdata1;
    logic [1:0]  s_tuser0, s_tuser1;
    logic        s_tlast0, s_tvalid0, s_tready0, m_tvalid0, m_tready0;
    logic        s_tlast1, s_tvalid1, s_tready1, m_tvalid1, m_tready1;
    logic        mosi0, sck0, busy0, mosi1, sck1, busy1, miso1, miso1_loop;
    logic [3:0]  cs_n0;
    logic [2:0]  cs_n1;

    assign miso1 = miso1_loop ? mosi1 : 1'b1;

    axis_spi_master #(.DATA_WIDTH(8), .NUM_CS(4), .CLK_DIV(4), .CPOL(0), .CPHA(0),
                      .CS_SETUP(2), .CS_HOLD(2)) dut0 (
        .clk(clk), .resetn(resetn),
        .s_axis_tdata(s_tdata0), .s_axis_tuser(s_tuser0), .s_axis_tlast(s_tlast0),
        .s_axis_tvalid(s_tvalid0), .s_axis_tready(s_tready0),
        .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready0),
        .MOSI(mosi0), .MISO(mosi0), .SCK(sck0), .CS_N(cs_n0), .busy(busy0)
    );

    axis_spi_master #(.DATA_WIDTH(8), .NUM_CS(3), .CLK_DIV(4), .CPOL(1), .CPHA(1),
                      .CS_SETUP(2), .CS_HOLD(2)) dut1 (
        .clk(clk), .resetn(resetn),
        .s_axis_tdata(s_tdata1), .s_axis_tuser(s_tuser1), .s_axis_tlast(s_tlast1),
        .s_axis_tvalid(s_tvalid1), .s_axis_tready(s_tready1),
        .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready1),
        .MOSI(mosi1), .MISO(miso1), .SCK(sck1), .CS_N(cs_n1), .busy(busy1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitors, sampled on the falling clk edge
    int          rise0 = 0, cs_low0 = 0, cs_fall0 = 0, tv_seen0 = 0;
    int          rise1 = 0, fall1 = 0, cs_low1 = 0;
    logic [31:0] mosi_bits0 = '0, mosi_bits1 = '0;
    logic [3:0]  cs_seen0 = 4'hF;
    logic [2:0]  cs_seen1 = 3'h7;
    logic        sck0_prev = 1'b0, sck1_prev = 1'b1, cs0_was_high = 1'b1;
    logic [31:0] rx0[$], rx1[$];

    always @(negedge clk) begin
        if (!sck0_prev && sck0) begin
            rise0++;
            mosi_bits0 = {mosi_bits0[30:0], mosi0};
        end
        sck0_prev = sck0;
        if (cs_n0 != 4'hF) begin
            cs_low0++;
            cs_seen0 = cs_n0;
            if (cs0_was_high) cs_fall0++;
        end
        cs0_was_high = (cs_n0 == 4'hF);
        if (m_tvalid0) tv_seen0++;
        if (m_tvalid0 && m_tready0) rx0.push_back(m_tdata0);

        if (sck1_prev && !sck1) fall1++;
        if (!sck1_prev && sck1) begin
            rise1++;
            mosi_bits1 = {mosi_bits1[30:0], mosi1};
        end
        sck1_prev = sck1;
        if (cs_n1 != 3'h7) begin
            cs_low1++;
            cs_seen1 = cs_n1;
        end
        if (m_tvalid1 && m_tready1) rx1.push_back(m_tdata1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rise0 = 0; cs_low0 = 0; cs_fall0 = 0; tv_seen0 = 0; mosi_bits0 = '0; cs_seen0 = 4'hF;
        rise1 = 0; fall1 = 0; cs_low1 = 0; mosi_bits1 = '0; cs_seen1 = 3'h7;
        rx0.delete(); rx1.delete();
    endtask

    task automatic present0(input logic [31:0] d, input logic [1:0] u, input logic l);
        s_tdata0 = d; s_tuser0 = u; s_tlast0 = l; s_tvalid0 = 1'b1;
    endtask

    task automatic complete0();
        int n = 0;
        while (!s_tready0 && n < 500) begin tick(1); n++; end
        if (!s_tready0) check_eq("s_tready0_wait", s_tready0, 1);
        tick(1);
        s_tvalid0 = 1'b0;
    endtask

    task automatic send1(input logic [31:0] d, input logic [1:0] u, input logic l);
        int n = 0;
        s_tdata1 = d; s_tuser1 = u; s_tlast1 = l; s_tvalid1 = 1'b1;
        while (!s_tready1 && n < 500) begin tick(1); n++; end
        if (!s_tready1) check_eq("s_tready1_wait", s_tready1, 1);
        tick(1);
        s_tvalid1 = 1'b0;
    endtask

    task automatic wait_done0(input int words);
        int n = 0;
        while ((rx0.size() < words || busy0) && n < 1000) begin tick(1); n++; end
        check_eq("rx0_count", 32'(rx0.size()), 32'(words));
        check_eq("busy0_end", busy0, 0);
    endtask

    task automatic wait_done1(input int words);
        int n = 0;
        while ((rx1.size() < words || busy1) && n < 1000) begin tick(1); n++; end
        check_eq("rx1_count", 32'(rx1.size()), 32'(words));
        check_eq("busy1_end", busy1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ready_seen;
        int rise_before;
        resetn = 1'b0; miso1_loop = 1'b0;
        s_tdata0 = '0; s_tuser0 = '0; s_tlast0 = 1'b0; s_tvalid0 = 1'b0; m_tready0 = 1'b1;
        s_tdata1 = '0; s_tuser1 = '0; s_tlast1 = 1'b0; s_tvalid1 = 1'b0; m_tready1 = 1'b1;

        // Reset values
        #12;
        check_eq("rst_cs_n0", cs_n0, 4'hF);
        check_eq("rst_sck0", sck0, 0);
        check_eq("rst_mosi0", mosi0, 0);
        check_eq("rst_busy0", busy0, 0);
        check_eq("rst_s_tready0", s_tready0, 0);
        check_eq("rst_m_tvalid0", m_tvalid0, 0);
        check_eq("rst_m_tdata0", m_tdata0, 0);
        check_eq("rst_sck1", sck1, 1);
        check_eq("rst_cs_n1", cs_n1, 3'h7);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_eq("s_tready0_before_edge", s_tready0, 0);
        tick(1);
        check_eq("s_tready0_first_edge", s_tready0, 1);

        // Single word, mode 0, tuser=2, loopback
        clear_mon();
        present0(32'hA5, 2'd2, 1'b1);
        complete0();
        wait_done0(1);
        tick(2);
        check_eq("single_rx", rx0[0], 32'h0000_00A5);
        check_eq("single_cs_low_cycles", cs_low0, 36);
        check_eq("single_cs_value", cs_seen0, 4'b1011);
        check_eq("single_sck_periods", rise0, 8);
        check_eq("single_mosi_bits", mosi_bits0[7:0], 8'hA5);
        check_eq("single_sck_idle", sck0, 0);
        check_eq("single_mosi_idle", mosi0, 0);

        // Burst: CS stays low across two words
        clear_mon();
        present0(32'h12, 2'd1, 1'b0);
        complete0();
        present0(32'h34, 2'd1, 1'b1);
        complete0();
        wait_done0(2);
        tick(2);
        check_eq("burst_rx_first", rx0[0], 32'h12);
        check_eq("burst_rx_second", rx0[1], 32'h34);
        check_eq("burst_cs_falls", cs_fall0, 1);
        check_eq("burst_cs_value", cs_seen0, 4'b1101);
        check_eq("burst_sck_periods", rise0, 16);
        check_eq("burst_mosi_bits", mosi_bits0[15:0], 16'h1234);

        // Backpressure: no new transfer while the RX word is pending
        clear_mon();
        m_tready0 = 1'b0;
        present0(32'h5A, 2'd0, 1'b1);
        complete0();
        n = 0;
        while (!m_tvalid0 && n < 500) begin tick(1); n++; end
        check_eq("bp_first_valid", m_tvalid0, 1);
        present0(32'h6B, 2'd0, 1'b1);
        rise_before = rise0;
        ready_seen = 0;
        repeat (60) begin
            tick(1);
            if (s_tready0) ready_seen++;
        end
        check_eq("bp_ready_held_low", ready_seen, 0);
        check_eq("bp_no_sck", rise0 - rise_before, 0);
        check_eq("bp_valid_held", m_tvalid0, 1);
        check_eq("bp_data_held", m_tdata0, 32'h5A);
        check_eq("bp_not_busy", busy0, 0);
        m_tready0 = 1'b1;
        complete0();
        wait_done0(2);
        check_eq("bp_rx_first", rx0[0], 32'h5A);
        check_eq("bp_rx_second", rx0[1], 32'h6B);

        // Reset in the middle of a word
        clear_mon();
        present0(32'hC3, 2'd0, 1'b1);
        complete0();
        n = 0;
        while (rise0 < 3 && n < 200) begin tick(1); n++; end
        check_eq("mid_rises_before_reset", rise0, 3);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_cs_n", cs_n0, 4'hF);
        check_eq("mid_rst_sck", sck0, 0);
        check_eq("mid_rst_mosi", mosi0, 0);
        check_eq("mid_rst_busy", busy0, 0);
        tick(3);
        resetn = 1'b1;
        tick(4);
        check_eq("mid_no_rx_word", 32'(rx0.size()), 0);
        check_eq("mid_no_valid", tv_seen0, 0);
        present0(32'h96, 2'd3, 1'b1);
        complete0();
        wait_done0(1);
        check_eq("mid_next_rx", rx0[0], 32'h96);
        check_eq("mid_next_cs", cs_seen0, 4'b0111);

        // Mode 3, MISO tied high
        clear_mon();
        miso1_loop = 1'b0;
        send1(32'h3C, 2'd1, 1'b1);
        wait_done1(1);
        tick(2);
        check_eq("mode3_rx", rx1[0], 32'hFF);
        check_eq("mode3_leading_edges", fall1, 8);
        check_eq("mode3_trailing_edges", rise1, 8);
        check_eq("mode3_mosi_bits", mosi_bits1[7:0], 8'h3C);
        check_eq("mode3_cs_value", cs_seen1, 3'b101);
        check_eq("mode3_cs_low_cycles", cs_low1, 36);
        check_eq("mode3_sck_idle", sck1, 1);

        // Unused chip select, loopback
        clear_mon();
        miso1_loop = 1'b1;
        send1(32'h81, 2'd3, 1'b1);
        wait_done1(1);
        check_eq("badsel_rx", rx1[0], 32'h81);
        check_eq("badsel_cs_never_low", cs_low1, 0);
        check_eq("badsel_sck_periods", fall1, 8);
        check_eq("badsel_mosi_bits", mosi_bits1[7:0], 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
